// File: rtl/req_enc_pkg.sv
// Shared definitions for the request encoder: sizes, FSM encoding and the
// fixed-priority encoder used to pick among pending requests.
package req_enc_pkg;

    localparam int W = 3;
    localparam int N = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Later loop iterations overwrite earlier ones, so the scan order sets the winner.
    function automatic logic [W-1:0] prio_encode(input logic [N-1:0] v, input logic msb_first);
        logic [W-1:0] idx;
        idx = '0;
        if (msb_first) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (v[i]) idx = W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing asynchronous request lines into the clk domain.
// Each bit is synchronised independently; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/req_encoder8to3.sv
// Captures eight asynchronous request lines into a sticky pending bitmap and
// issues them one at a time as 3-bit indices over a valid/ready handshake.
import req_enc_pkg::*;

module req_encoder8to3 #(
    parameter bit EDGE_MODE = 1'b1,
    parameter bit PRIO_MSB  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         overrun
);

    logic [N-1:0] w_s2;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic         w_accept;

    logic [N-1:0] r_prev;
    logic [N-1:0] r_pending;
    logic         r_overrun;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_code;
    logic [W-1:0] w_code_nxt;
    logic         r_valid;
    logic         w_valid_nxt;

    sync_2ff #(
        .WIDTH (N)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (w_s2)
    );

    // ---- stage: edge detect, set/clear terms
    assign w_rise   = w_s2 & ~r_prev;
    assign w_set    = EDGE_MODE ? w_rise : w_s2;
    assign w_accept = r_valid & ready;

    always_comb begin
        w_clr = '0;
        if (w_accept) w_clr[r_code] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_prev    <= w_s2;
            // A set wins over a clear on the same bit, so a re-request at accept is kept.
            r_pending <= w_set | (r_pending & ~w_clr);
            r_overrun <= EDGE_MODE & (|(w_rise & r_pending & ~w_clr));
        end
    end

    // ---- stage: issue FSM
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (r_pending != '0) begin
                    w_code_nxt  = prio_encode(r_pending, PRIO_MSB);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_req_encoder8to3.sv
// Directed bench for req_encoder8to3: edge/MSB, edge/LSB and level/MSB variants
// share one stimulus; outputs are compared against hand-computed values.
module tb_req_encoder8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;

    logic [2:0] code_m, code_l, code_v;
    logic       valid_m, valid_l, valid_v;
    logic [7:0] pend_m, pend_l, pend_v;
    logic       ovr_m, ovr_l, ovr_v;

    int checks;
    int errors;

    req_encoder8to3 #(.EDGE_MODE(1'b1), .PRIO_MSB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code_m), .valid(valid_m),
        .ready(ready), .pending(pend_m), .overrun(ovr_m)
    );

    req_encoder8to3 #(.EDGE_MODE(1'b1), .PRIO_MSB(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code_l), .valid(valid_l),
        .ready(ready), .pending(pend_l), .overrun(ovr_l)
    );

    req_encoder8to3 #(.EDGE_MODE(1'b0), .PRIO_MSB(1'b1)) dut_v (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code_v), .valid(valid_v),
        .ready(ready), .pending(pend_v), .overrun(ovr_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout act=running exp=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] code;
        logic [7:0] pend;
        logic       ovr;
        logic [2:0] code_l;
        logic [7:0] pend_l;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'hFF;
        ready  = 1'b0;

        // Reset with all requests high: nothing propagates.
        tick();
        tick();
        chk("rst_valid",   valid_m, 0);
        chk("rst_code",    code_m,  0);
        chk("rst_pending", pend_m,  0);
        chk("rst_overrun", ovr_m,   0);
        rst_n = 1'b1;
        tick();
        chk("rel_e0_pending", pend_m, 8'h00);
        tick();
        chk("rel_e1_pending", pend_m, 8'h00);
        tick();
        chk("rel_e2_pending", pend_m, 8'hFF);
        chk("rel_e2_valid",   valid_m, 0);
        chk("rel_e2_overrun", ovr_m, 0);
        tick();
        chk("rel_e3_valid",  valid_m, 1);
        chk("rel_e3_code",   code_m, 7);
        chk("rel_e3_code_l", code_l, 0);

        // Single edge, then simultaneous 8'h22 with both priorities.
        tbl[0]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[2]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h08, 1'b0, 3'd0, 8'h08};
        tbl[3]  = '{8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0, 3'd3, 8'h08};
        tbl[4]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[5]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[6]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[7]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[8]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[9]  = '{8'h22, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[10] = '{8'h22, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[11] = '{8'h22, 1'b1, 1'b0, 3'd0, 8'h22, 1'b0, 3'd0, 8'h22};
        tbl[12] = '{8'h22, 1'b1, 1'b1, 3'd5, 8'h22, 1'b0, 3'd1, 8'h22};
        tbl[13] = '{8'h22, 1'b1, 1'b0, 3'd0, 8'h02, 1'b0, 3'd0, 8'h20};
        tbl[14] = '{8'h22, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 3'd5, 8'h20};
        tbl[15] = '{8'h22, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[16] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            req   = tbl[i].req;
            ready = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_valid", i),   valid_m, tbl[i].v);
            chk($sformatf("tbl%0d_pending", i), pend_m,  tbl[i].pend);
            chk($sformatf("tbl%0d_overrun", i), ovr_m,   tbl[i].ovr);
            chk($sformatf("tbl%0d_valid_l", i), valid_l, tbl[i].v);
            chk($sformatf("tbl%0d_pend_l", i),  pend_l,  tbl[i].pend_l);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_code", i),   code_m, tbl[i].code);
                chk($sformatf("tbl%0d_code_l", i), code_l, tbl[i].code_l);
            end
        end

        // Backpressure: code held stable while ready is low.
        do_reset();
        req = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_valid", i), valid_m, 1);
            chk($sformatf("bp%0d_code", i),  code_m, 0);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("bp_acc_valid",   valid_m, 0);
        chk("bp_acc_pending", pend_m, 8'h00);
        ready = 1'b0;

        // Overrun: second edge on bit 4 while it is still pending in HOLD.
        do_reset();
        req = 8'h10;
        for (int i = 0; i < 4; i++) tick();
        chk("ov_hold_valid", valid_m, 1);
        chk("ov_hold_code",  code_m, 4);
        req = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        req = 8'h10;
        tick();
        tick();
        chk("ov_pre_overrun", ovr_m, 0);
        tick();
        chk("ov_pulse",        ovr_m, 1);
        chk("ov_pulse_pend",   pend_m, 8'h10);
        tick();
        chk("ov_pulse_end",    ovr_m, 0);
        chk("ov_still_valid",  valid_m, 1);
        // Same edge coinciding with the accept: bit stays set, no pulse.
        req = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        req = 8'h10;
        tick();
        tick();
        ready = 1'b1;
        tick();
        chk("ov_acc_overrun", ovr_m, 0);
        chk("ov_acc_pending", pend_m, 8'h10);
        chk("ov_acc_valid",   valid_m, 0);
        ready = 1'b0;
        tick();
        chk("ov_reissue_valid", valid_m, 1);
        chk("ov_reissue_code",  code_m, 4);

        // Level mode re-issues a held request after every accept.
        do_reset();
        req   = 8'h08;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("lv_valid1", valid_v, 1);
        chk("lv_code1",  code_v, 3);
        tick();
        chk("lv_acc_valid",   valid_v, 0);
        chk("lv_acc_pending", pend_v, 8'h08);
        tick();
        chk("lv_valid2",  valid_v, 1);
        chk("lv_code2",   code_v, 3);
        chk("lv_overrun", ovr_v, 0);

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        req = 8'h40;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_hold_valid", valid_m, 1);
        chk("ar_hold_code",  code_m, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",   valid_m, 0);
        chk("ar_code",    code_m, 0);
        chk("ar_pending", pend_m, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
